// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: counter width
// and the default horizontal/vertical timing.
package video_timing_pkg;

   localparam int CNT_W = 9;

   localparam int H_TOTAL_D      = 384;
   localparam int HBLANK_START_D = 256;
   localparam int HSYNC_START_D  = 288;
   localparam int HSYNC_END_D    = 320;

   localparam int V_TOTAL_D      = 264;
   localparam int VBLANK_START_D = 224;
   localparam int VSYNC_START_D  = 240;
   localparam int VSYNC_END_D    = 244;

   // Half-open range test [lo, hi) on a counter value.
   function automatic logic in_range(
      input logic [CNT_W-1:0] c,
      input logic [CNT_W-1:0] lo,
      input logic [CNT_W-1:0] hi
   );
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with clock enable and synchronous clear.
// Ports: clk, clr, ce in; count, count_next, tc (count == MOD-1) out.
module mod_counter
   import video_timing_pkg::*;
#(
   parameter int MOD = 384
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ce,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next,
   output logic             tc
);

   assign tc         = (count == CNT_W'(MOD - 1));
   assign count_next = tc ? '0 : count + 1'b1;

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (ce) begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: h/v counters, blank/sync decodes, sync
// edge strobes, frame start strobe and optional vblank interrupt.
// Ports: clk, clr (sync reset), ce, irq_ack in; hcount, vcount,
// hblank, vblank, hsync, vsync, n_hs_pre, n_hs_clr, frame_start, irq out.
// Macro VIDEO_TIMING_VBL_IRQ_EN enables the vblank interrupt.
module video_timing
   import video_timing_pkg::*;
#(
   parameter int H_TOTAL      = H_TOTAL_D,
   parameter int HBLANK_START = HBLANK_START_D,
   parameter int HSYNC_START  = HSYNC_START_D,
   parameter int HSYNC_END    = HSYNC_END_D,
   parameter int V_TOTAL      = V_TOTAL_D,
   parameter int VBLANK_START = VBLANK_START_D,
   parameter int VSYNC_START  = VSYNC_START_D,
   parameter int VSYNC_END    = VSYNC_END_D
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ce,
   input  logic             irq_ack,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hblank,
   output logic             vblank,
   output logic             hsync,
   output logic             vsync,
   output logic             n_hs_pre,
   output logic             n_hs_clr,
   output logic             frame_start,
   output logic             irq
);

   if (!(HBLANK_START > 0 && HBLANK_START < H_TOTAL &&
         HSYNC_START < HSYNC_END && HSYNC_END < H_TOTAL &&
         H_TOTAL <= (1 << CNT_W))) begin : g_bad_h
      $error("video_timing: illegal horizontal timing parameters");
   end

   if (!(VBLANK_START > 0 && VBLANK_START < V_TOTAL &&
         VSYNC_START < VSYNC_END && VSYNC_END <= V_TOTAL &&
         V_TOTAL <= (1 << CNT_W))) begin : g_bad_v
      $error("video_timing: illegal vertical timing parameters");
   end

   localparam logic [CNT_W-1:0] HBS = CNT_W'(HBLANK_START);
   localparam logic [CNT_W-1:0] HSS = CNT_W'(HSYNC_START);
   localparam logic [CNT_W-1:0] HSE = CNT_W'(HSYNC_END);
   localparam logic [CNT_W-1:0] HT  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] VBS = CNT_W'(VBLANK_START);
   localparam logic [CNT_W-1:0] VSS = CNT_W'(VSYNC_START);
   localparam logic [CNT_W-1:0] VSE = CNT_W'(VSYNC_END - 1);

   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;
   logic [CNT_W-1:0] v_nxt_eff;
   logic             h_tc;
   logic             v_tc;

   mod_counter #(.MOD(H_TOTAL)) u_hcnt (
      .clk        (clk),
      .clr        (clr),
      .ce         (ce),
      .count      (hcount),
      .count_next (h_next),
      .tc         (h_tc)
   );

   mod_counter #(.MOD(V_TOTAL)) u_vcnt (
      .clk        (clk),
      .clr        (clr),
      .ce         (ce & h_tc),
      .count      (vcount),
      .count_next (v_next),
      .tc         (v_tc)
   );

   // Line count only moves on the h wrap.
   assign v_nxt_eff = h_tc ? v_next : vcount;

   // Decodes use the counter's next value so the registered flag lines
   // up with the counter it describes. vsync uses an inclusive top so
   // VSYNC_END == V_TOTAL stays representable in CNT_W bits.
   always_ff @(posedge clk) begin
      if (clr) begin
         hblank      <= 1'b0;
         vblank      <= 1'b0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         n_hs_pre    <= 1'b1;
         n_hs_clr    <= 1'b1;
         frame_start <= 1'b0;
      end else if (ce) begin
         hblank      <= (h_next >= HBS) && (h_next <= HT);
         vblank      <= (v_nxt_eff >= VBS);
         hsync       <= in_range(h_next, HSS, HSE);
         vsync       <= (v_nxt_eff >= VSS) && (v_nxt_eff <= VSE);
         n_hs_pre    <= (h_next != HSS);
         n_hs_clr    <= (h_next != HSE);
         frame_start <= h_tc && v_tc;
      end else begin
         n_hs_pre    <= 1'b1;
         n_hs_clr    <= 1'b1;
         frame_start <= 1'b0;
      end
   end

`ifdef VIDEO_TIMING_VBL_IRQ_EN
   logic irq_set;

   // A set arriving with an ack wins.
   assign irq_set = ce && h_tc && (v_next == VBS);

   always_ff @(posedge clk) begin
      if (clr) begin
         irq <= 1'b0;
      end else begin
         irq <= irq_set | (irq & ~irq_ack);
      end
   end
`else
   logic unused_irq_ack;

   assign unused_irq_ack = irq_ack;
   assign irq            = 1'b0;
`endif

   logic unused_v_tc_only;
   assign unused_v_tc_only = v_tc & 1'b0;

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter H_TOTAL, default 384, pixel clocks per line.
REQ-002 SHALL have parameter HBLANK_START, default 256, first blanked hcount.
REQ-003 SHALL have parameters HSYNC_START/HSYNC_END, defaults 288/320, hsync active range [START, END).
REQ-004 SHALL have parameter V_TOTAL, default 264, lines per frame.
REQ-005 SHALL have parameter VBLANK_START, default 224, first blanked vcount.
REQ-006 SHALL have parameters VSYNC_START/VSYNC_END, defaults 240/244, vsync active range [START, END).
REQ-007 SHALL have ports: clk in 1, sole clock, rising-edge; reset is synchronous and active-high.
REQ-008 SHALL have port clr in 1, the synchronous active-high reset.
REQ-009 SHALL have port ce in 1, pixel clock enable; all state advances only when ce=1.
REQ-010 SHALL have ports hcount out 9 and vcount out 9, current position.
REQ-011 SHALL have ports hblank, vblank, hsync, vsync out 1 each, active-high.
REQ-012 SHALL have ports n_hs_pre, n_hs_clr out 1 each, active-low one-cycle strobes for downstream dual D flip-flop preset/clear pins.
REQ-013 SHALL have port frame_start out 1, one-cycle strobe at hcount=0, vcount=0.
REQ-014 SHALL have ports irq out 1 and irq_ack in 1 (see Configuration).

Function
REQ-015 SHALL increment hcount on each clk with ce=1; H_TOTAL-1 wraps to 0.
REQ-016 SHALL increment vcount on the same ce cycle hcount wraps; V_TOTAL-1 wraps to 0.
REQ-017 SHALL hold all state, outputs and strobes (strobes inactive) on cycles with ce=0.
REQ-018 SHALL register hblank/vblank/hsync/vsync so each equals its range decode of the hcount/vcount presented in the same cycle (zero relative latency).
REQ-019 SHALL drive n_hs_pre low for exactly one clk cycle when hcount becomes HSYNC_START with ce=1 the following cycle qualifying; else high.
REQ-020 SHALL drive n_hs_clr low for exactly one clk cycle when hcount becomes HSYNC_END under the same rule; else high.
REQ-021 SHALL assert frame_start for one clk cycle when the counters become (0,0).
REQ-022 SHALL treat parameter misordering (e.g. HSYNC_END <= HSYNC_START) as illegal; elaboration-time assertion fails.

Reset
REQ-023 SHALL on clr=1 (ce ignored) set hcount=0, vcount=0, hblank/vblank/hsync/vsync=0, irq=0, frame_start=0, n_hs_pre=n_hs_clr=1.
REQ-024 SHALL resume counting from (0,0) on the first ce cycle after clr deasserts, without emitting frame_start for the reset position.
REQ-025 SHALL let clr asserted mid-line/mid-frame abort immediately; no partial strobes after the reset edge.

Configuration
REQ-026 SHALL compile the vblank interrupt only when macro VIDEO_TIMING_VBL_IRQ_EN is defined.
REQ-027 With macro: irq SHALL set on the clk where vcount becomes VBLANK_START and hold until a clk with irq_ack=1; simultaneous set and ack SHALL leave irq=1.
REQ-028 Without macro: irq SHALL be constant 0 and irq_ack ignored; ports remain present.

Structure
REQ-029 SHALL place default timing constants and CNT_W=9 in package video_timing_pkg.
REQ-030 SHALL implement each counter with sub-module mod_counter (parametric modulus, ce, sync clr, terminal-count output), instantiated twice.

Verification
REQ-031 Reset then 384 ce cycles -> hcount wraps 383->0, vcount 0->1 on same cycle.
REQ-032 Run full frame (384*264 ce cycles) -> frame_start exactly once, at (0,0) after wrap from (383,263).
REQ-033 hcount 287->288 -> n_hs_pre low one cycle, hsync=1 through 319, n_hs_clr low one cycle at 320, hsync=0.
REQ-034 ce toggled 1/0 alternately -> counts advance only on ce=1 cycles; strobes never wider than one cycle.
REQ-035 With VIDEO_TIMING_VBL_IRQ_EN: vcount reaches 224 with irq_ack=1 same cycle -> irq=1; ack next cycle -> irq=0; without macro irq stays 0.
REQ-036 clr asserted at (300,230) -> next cycle all outputs at reset values, no n_hs_clr strobe at 320.
